// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex seven-segment scan controller with a valid/ready digit register file.
// Optional leading-zero suppression when HEX_SCAN_LZS_EN is defined.
module hex_scan_ctrl #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned PERIOD = 50000,
   parameter int unsigned GUARD  = 500,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [2:0]        wr_addr,
   input  logic [3:0]        wr_data,
   input  logic              wr_blank,
   output logic [6:0]        seg_n,
   output logic [DIGITS-1:0] dig_n
);

   localparam int unsigned      PTR_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DIGITS - 1);
   localparam logic [6:0]       SEG_OFF    = 7'h7F;

   typedef enum logic [1:0] {
      S_LOAD,
      S_SHOW,
      S_GUARD
   } state_t;

   state_t              state, state_d;
   logic [PTR_W-1:0]    ptr, ptr_d, ptr_nxt;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [3:0]          val [DIGITS];
   logic [DIGITS-1:0]   blank;
   logic [3:0]          sh_val, sh_val_d;
   logic                sh_blank, sh_blank_d;
   logic [6:0]          seg_d;
   logic [DIGITS-1:0]   dig_d;
   logic                wr_hit;
   logic                lz_hide;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Writes are only refused during the single LOAD cycle, so LOAD never races a write.
   assign wr_ready = (state != S_LOAD);
   assign wr_hit   = wr_valid && wr_ready && (32'(wr_addr) < DIGITS);
   assign ptr_nxt  = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

`ifdef HEX_SCAN_LZS_EN
   // Hide this digit when nothing at or above it carries a visible nonzero value.
   always_comb begin
      lz_hide = (ptr != '0);
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (i >= int'(ptr) && !blank[i] && val[i] != 4'h0) lz_hide = 1'b0;
      end
   end
`else
   assign lz_hide = 1'b0;
`endif

   // Register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val   <= '{default: 4'h0};
         blank <= '1;
      end else if (wr_hit) begin
         val[wr_addr[PTR_W-1:0]]   <= wr_data;
         blank[wr_addr[PTR_W-1:0]] <= wr_blank;
      end
   end

   // State, pointer, counter, shadow and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_LOAD;
         ptr      <= '0;
         cnt      <= '0;
         sh_val   <= 4'h0;
         sh_blank <= 1'b1;
         seg_n    <= SEG_OFF;
         dig_n    <= '1;
      end else begin
         state    <= state_d;
         ptr      <= ptr_d;
         cnt      <= cnt_d;
         sh_val   <= sh_val_d;
         sh_blank <= sh_blank_d;
         seg_n    <= seg_d;
         dig_n    <= dig_d;
      end
   end

   // Next-state logic; outputs only move on entering and leaving SHOW
   always_comb begin
      state_d    = state;
      ptr_d      = ptr;
      cnt_d      = cnt + CNT_W'(1);
      sh_val_d   = sh_val;
      sh_blank_d = sh_blank;
      seg_d      = seg_n;
      dig_d      = dig_n;
      case (state)
         S_LOAD: begin
            sh_val_d   = val[ptr];
            sh_blank_d = blank[ptr] | lz_hide;
            seg_d      = sh_blank_d ? SEG_OFF : decode(sh_val_d);
            dig_d      = ~(DIGITS'(1) << ptr);
            cnt_d      = '0;
            state_d    = S_SHOW;
         end
         S_SHOW: begin
            if (cnt == SHOW_LAST) begin
               seg_d = SEG_OFF;
               dig_d = '1;
               cnt_d = '0;
               if (GUARD == 0) begin
                  state_d = S_LOAD;
                  ptr_d   = ptr_nxt;
               end else begin
                  state_d = S_GUARD;
               end
            end
         end
         S_GUARD: begin
            if (cnt == GUARD_LAST) begin
               cnt_d   = '0;
               state_d = S_LOAD;
               ptr_d   = ptr_nxt;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_LOAD;
         end
      endcase
   end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller that shares one hex-to-seven-segment decode path across up to eight common-anode digits. It holds a per-digit value/blank register file written through a valid/ready port. It sequences digit enables through a load/show/guard state machine so that only one digit is driven at a time and ghosting is suppressed. It sits between the board's control logic and the physical segment/digit pins.

## Interface

- `DIGITS`, 4: number of scanned digits, legal range 1..8.
- `PERIOD`, 50000: cycles each digit is driven, ≥1.
- `GUARD`, 500: all-off cycles after each digit, ≥0.
- `CNT_W`, 16: width of the slot counter; must hold max(PERIOD, GUARD)−1.

- `clk` input 1: the block's single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: write can be accepted this cycle.
- `wr_addr` input 3: target digit index; 0 = least significant.
- `wr_data` input 4: hex value 0x0–0xF.
- `wr_blank` input 1: 1 = digit dark, 0 = digit shows `wr_data`.
- `seg_n` output 7: active-low segments, bit0=a … bit6=g.
- `dig_n` output DIGITS: active-low digit enables.

## Operation

- **Register file:** DIGITS entries of {value[3:0], blank}.
- **Write acceptance:** a write is accepted on a cycle where `wr_valid` and `wr_ready` are both 1, and updates entry `wr_addr` on that edge.
- **Out-of-range writes:** if `wr_addr` ≥ DIGITS, the write is accepted and discarded.
- **Requester obligation:** the requester holds `wr_valid`, `wr_addr`, `wr_data` and `wr_blank` stable until the write is accepted.
- **State machine:** states LOAD, SHOW, GUARD; digit pointer `ptr`.
  - LOAD (1 cycle): copy entry[ptr] into a shadow register; `wr_ready`=0. Next state is SHOW.
  - SHOW (PERIOD cycles): drive `dig_n[ptr]`=0 with `seg_n` = decode(shadow), or 7'h7F if the shadow blank flag is set. Next state is GUARD, or LOAD if GUARD=0.
  - GUARD (GUARD cycles): `dig_n` all 1, `seg_n`=7'h7F. Next state is LOAD.
  - On leaving SHOW/GUARD to LOAD, `ptr` advances and wraps from DIGITS−1 to 0.
- **`wr_ready`:** 1 in SHOW and GUARD, 0 in LOAD.
- **Decode patterns (active low):** 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex). Blank → 7F.
- **Write to the displayed digit:** a write to digit `ptr` during its SHOW does not change the current window; it appears on the next visit.
- **Reset values:** all values 0, all blank flags 1, state LOAD, `ptr`=0, counter 0, `seg_n`=7'h7F, `dig_n`=all ones. `wr_ready` is 0 while in LOAD.
- **Reset mid-operation:** outputs go to their reset values immediately, without waiting for a clock. Any pending write is lost.

## Timing

- **Registered outputs:** `seg_n` and `dig_n` are registered. They change on the edge that enters SHOW and on the edge that leaves SHOW.
- **Slot length:** 1+PERIOD+GUARD cycles per digit; full frame is DIGITS×slot.
- **`wr_ready`:** combinational from the state register only; no path from `wr_valid`.
- **Write latency:** an accepted write is visible from the next LOAD of that digit. Worst case is one frame plus one cycle.
- **First LOAD after reset:** occurs on the first rising edge after `rst` deasserts; SHOW for digit 0 begins on the edge after that.
- **Counter:** counts 0..PERIOD−1 in SHOW and 0..GUARD−1 in GUARD, clearing on each state change.

## Configuration

- **`HEX_SCAN_LZS_EN` defined:** leading-zero suppression. In LOAD, if no entry at an index ≥ ptr holds an unblanked nonzero value and ptr≠0, the shadow is forced blank. Digit 0 is never suppressed.
- **`HEX_SCAN_LZS_EN` undefined:** entries are displayed exactly as written.

## Test plan

Common parameters: DIGITS=4, PERIOD=4, GUARD=2 (slot 7, frame 28).

- **Reset:** assert `rst` for 3 cycles, then release → `seg_n`=7F and `dig_n`=F during reset; first frame is all dark; `wr_ready`=0 on each LOAD cycle and 1 otherwise.
- **Basic display:** write d0=1, d1=A, d2=F, d3=0, all unblanked, then wait a full frame → per slot, 4 cycles of `dig_n`=E/`seg_n`=79, D/08, B/0E, 7/40, each followed by 2 cycles of F/7F.
- **Write held across LOAD:** raise `wr_valid` on the LOAD cycle → no accept on that edge; accepted on the next edge; entry updated exactly once.
- **Write to displayed digit:** write d1=8 during d1's SHOW → `seg_n` stays 08 for the rest of the window; shows 00 on d1's next slot.
- **Out-of-range address and async reset:** a write to addr 5 is accepted with no visible change. Asserting `rst` mid-SHOW drives `seg_n`=7F and `dig_n`=F before the next clock edge.
- **`HEX_SCAN_LZS_EN` defined:** write d3=0, d2=0, d1=5, d0=0, all unblanked → d3 and d2 dark, d1 shows 12, d0 shows 40.
